// File: rtl/status_flags.sv
// status_flags: processor status register (P) stage behind the ALU.
// Holds the six architectural flags N,V,D,I,Z,C. It applies ALU results,
// flag instructions and PLP/RTI loads, formats P for PHP/BRK pushes, and
// qualifies IRQ/NMI requests for the sequencer.
//
// Build option: define STATUS_FLAGS_CMOS_DCLR_EN to make int_entry also clear D
// (65C02 behaviour). Without it, D is left alone on interrupt entry (NMOS).

module status_flags #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       upd_bit,
  input  logic [2:0] flag_op,
  input  logic       load_en,
  input  logic [7:0] load_data,
  input  logic       int_entry,
  input  logic       brk_push,
  input  logic       irq,
  input  logic       nmi,
  input  logic       nmi_ack,
  output logic [7:0] p_out,
  output logic [7:0] push_data,
  output logic       carry_to_alu,
  output logic       decimal_to_alu,
  output logic       irq_req,
  output logic       nmi_req
);

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_CLC  = 3'b001,
    OP_SEC  = 3'b010,
    OP_CLI  = 3'b011,
    OP_SEI  = 3'b100,
    OP_CLD  = 3'b101,
    OP_SED  = 3'b110,
    OP_CLV  = 3'b111
  } flag_op_e;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic irq_req_q, irq_req_d;
  logic nmi_req_q, nmi_req_d;
  logic nmi_prev_q, nmi_prev_d;

  logic     result_zero;
  flag_op_e op;

  assign result_zero = (alu_result == 8'h00);
  assign op          = flag_op_e'(flag_op);

  // Next flag values. Assignments are layered lowest priority first, so each
  // later write overrides only the bits it touches.
  always_comb begin
    // NOTE: every output gets a hold default first, so no path can infer a latch.
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;

    if (load_en) begin
      // PLP/RTI replaces the whole register; bits 5 and 4 are not stored.
      n_d = load_data[7];
      v_d = load_data[6];
      d_d = load_data[3];
      i_d = load_data[2];
      z_d = load_data[1];
      c_d = load_data[0];
    end else begin
      // Plain ALU result capture.
      if (upd_nz) begin
        n_d = alu_result[7];
        z_d = result_zero;
      end
      if (upd_c) c_d = alu_carry;
      if (upd_v) v_d = alu_overflow;

      // BIT takes N/V from the operand itself rather than the ALU.
      if (upd_bit) begin
        n_d = load_data[7];
        v_d = load_data[6];
        z_d = result_zero;
      end

      // Explicit flag instructions override the ALU-driven writes.
      unique case (op)
        OP_CLC:  c_d = 1'b0;
        OP_SEC:  c_d = 1'b1;
        OP_CLI:  i_d = 1'b0;
        OP_SEI:  i_d = 1'b1;
        OP_CLD:  d_d = 1'b0;
        OP_SED:  d_d = 1'b1;
        OP_CLV:  v_d = 1'b0;
        default: ;
      endcase

      // Interrupt entry must mask further IRQs even if a CLI is in flight.
      if (int_entry) begin
        i_d = 1'b1;
`ifdef STATUS_FLAGS_CMOS_DCLR_EN
        d_d = 1'b0;
`endif
      end
    end
  end

  // Interrupt qualification. The IRQ mask uses the I value before this
  // edge's update, giving the one-instruction CLI/SEI latency of the 6502.
  always_comb begin
    irq_req_d  = irq & ~i_q;
    nmi_prev_d = nmi;
    nmi_req_d  = nmi_req_q;
    if (nmi_ack)          nmi_req_d = 1'b0;
    if (nmi & ~nmi_prev_q) nmi_req_d = 1'b1;  // a new edge beats the ack
  end

  // State register with asynchronous reset to RESET_P.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      n_q        <= RESET_P[7];
      v_q        <= RESET_P[6];
      d_q        <= RESET_P[3];
      i_q        <= RESET_P[2];
      z_q        <= RESET_P[1];
      c_q        <= RESET_P[0];
      irq_req_q  <= 1'b0;
      nmi_req_q  <= 1'b0;
      nmi_prev_q <= 1'b0;
    end else begin
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      irq_req_q  <= irq_req_d;
      nmi_req_q  <= nmi_req_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

  assign p_out          = {n_q, v_q, 1'b1, 1'b0,     d_q, i_q, z_q, c_q};
  assign push_data      = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign carry_to_alu   = c_q;
  assign decimal_to_alu = d_q;
  assign irq_req        = irq_req_q;
  assign nmi_req        = nmi_req_q;

endmodule

// File: tb/tb_status_flags.sv
// Self-checking bench for status_flags: directed cases plus a random phase
// checked against a small reference model via an expectation queue.

module tb_status_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_result;
  logic       alu_carry, alu_overflow;
  logic       upd_nz, upd_c, upd_v, upd_bit;
  logic [2:0] flag_op;
  logic       load_en;
  logic [7:0] load_data;
  logic       int_entry, brk_push, irq, nmi, nmi_ack;
  logic [7:0] p_out, push_data;
  logic       carry_to_alu, decimal_to_alu, irq_req, nmi_req;

  status_flags dut (
    .clk            (clk),
    .rst            (rst),
    .alu_result     (alu_result),
    .alu_carry      (alu_carry),
    .alu_overflow   (alu_overflow),
    .upd_nz         (upd_nz),
    .upd_c          (upd_c),
    .upd_v          (upd_v),
    .upd_bit        (upd_bit),
    .flag_op        (flag_op),
    .load_en        (load_en),
    .load_data      (load_data),
    .int_entry      (int_entry),
    .brk_push       (brk_push),
    .irq            (irq),
    .nmi            (nmi),
    .nmi_ack        (nmi_ack),
    .p_out          (p_out),
    .push_data      (push_data),
    .carry_to_alu   (carry_to_alu),
    .decimal_to_alu (decimal_to_alu),
    .irq_req        (irq_req),
    .nmi_req        (nmi_req)
  );

  always #5 clk = ~clk;

  typedef enum {K_P, K_PUSH, K_IRQ, K_NMI, K_C2A, K_D2A} kind_e;
  typedef struct {
    string      tag;
    kind_e      kind;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [2:0] CLC = 3'd1, SEC = 3'd2, CLI = 3'd3, SEI = 3'd4,
                         CLD = 3'd5, SED = 3'd6, CLV = 3'd7;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input kind_e kind, input logic [7:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Compare every pending expectation against the DUT as it stands now.
  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_P:     obs = p_out;
        K_PUSH:  obs = push_data;
        K_IRQ:   obs = {7'd0, irq_req};
        K_NMI:   obs = {7'd0, nmi_req};
        K_C2A:   obs = {7'd0, carry_to_alu};
        default: obs = {7'd0, decimal_to_alu};
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle_inputs();
    alu_result = 8'h00; alu_carry = 1'b0; alu_overflow = 1'b0;
    upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; upd_bit = 1'b0;
    flag_op = 3'd0; load_en = 1'b0; load_data = 8'h00;
    int_entry = 1'b0; brk_push = 1'b0; nmi_ack = 1'b0;
  endtask

  // Reference model state.
  logic m_n, m_v, m_d, m_i, m_z, m_c, m_irq, m_nmi, m_prev;

  function automatic logic [7:0] m_p();
    return {m_n, m_v, 1'b1, 1'b0, m_d, m_i, m_z, m_c};
  endfunction

  // One clock edge of the model, written per flag.
  task automatic model_step();
    logic n, v, d, i, z, c;
    if (load_en) begin
      {n, v} = load_data[7:6];
      {d, i, z, c} = load_data[3:0];
    end else begin
      c = (flag_op == CLC) ? 1'b0 : (flag_op == SEC) ? 1'b1 : upd_c ? alu_carry : m_c;
      v = (flag_op == CLV) ? 1'b0 : upd_bit ? load_data[6] : upd_v ? alu_overflow : m_v;
      n = upd_bit ? load_data[7] : upd_nz ? alu_result[7] : m_n;
      z = (upd_bit || upd_nz) ? (alu_result == 8'h00) : m_z;
      i = int_entry ? 1'b1 : (flag_op == CLI) ? 1'b0 : (flag_op == SEI) ? 1'b1 : m_i;
`ifdef STATUS_FLAGS_CMOS_DCLR_EN
      d = int_entry ? 1'b0 : (flag_op == CLD) ? 1'b0 : (flag_op == SED) ? 1'b1 : m_d;
`else
      d = (flag_op == CLD) ? 1'b0 : (flag_op == SED) ? 1'b1 : m_d;
`endif
    end
    m_irq  = irq & ~m_i;
    m_nmi  = (nmi & ~m_prev) ? 1'b1 : nmi_ack ? 1'b0 : m_nmi;
    m_prev = nmi;
    {m_n, m_v, m_d, m_i, m_z, m_c} = {n, v, d, i, z, c};
  endtask

  initial begin
    rst = 1'b1; irq = 1'b0; nmi = 1'b0;
    idle_inputs();
    #12 rst = 1'b0;

    // Reset state.
    expect_v("reset_p", K_P, 8'h24);
    expect_v("reset_irq", K_IRQ, 8'h00);
    expect_v("reset_nmi", K_NMI, 8'h00);
    expect_v("reset_c2a", K_C2A, 8'h00);
    drain();
    tick();
    expect_v("idle_p", K_P, 8'h24);
    drain();

    // SED, then asynchronous reset part way through the next SED.
    flag_op = SED; expect_v("sed_p", K_P, 8'h2C); expect_v("sed_d2a", K_D2A, 8'h01); tick();
    #2 rst = 1'b1;
    #1 expect_v("async_rst_p", K_P, 8'h24); drain();
    flag_op = 3'd0;
    #1 rst = 1'b0;
    tick();

    // ALU capture.
    alu_result = 8'h80; alu_carry = 1'b1; alu_overflow = 1'b1;
    upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
    expect_v("alu_nvc_p", K_P, 8'hE5); tick();
    idle_inputs(); upd_nz = 1'b1; alu_result = 8'h00;
    expect_v("alu_zero_p", K_P, 8'h67); expect_v("c2a_set", K_C2A, 8'h01); tick();

    // Flag op priority over upd_c, and load over everything.
    idle_inputs(); flag_op = CLC; expect_v("clc_p", K_P, 8'h66); tick();
    flag_op = SEC; upd_c = 1'b1; alu_carry = 1'b0; expect_v("sec_over_updc", K_P, 8'h67); tick();
    idle_inputs(); flag_op = CLV; upd_v = 1'b1; alu_overflow = 1'b1;
    expect_v("clv_over_updv", K_P, 8'h27); tick();
    idle_inputs(); load_en = 1'b1; load_data = 8'hFF; flag_op = CLC; int_entry = 1'b0;
    expect_v("load_over_clc", K_P, 8'hEF); tick();

    // PHP/BRK formatting.
    idle_inputs(); load_en = 1'b1; load_data = 8'h24; expect_v("load_24", K_P, 8'h24); tick();
    idle_inputs(); brk_push = 1'b1; #1 expect_v("push_brk", K_PUSH, 8'h34); drain();
    brk_push = 1'b0; #1 expect_v("push_php", K_PUSH, 8'h24); drain();

    // IRQ qualification and CLI/SEI latency.
    irq = 1'b1; expect_v("irq_masked", K_IRQ, 8'h00); tick();
    flag_op = CLI; expect_v("cli_edge1", K_IRQ, 8'h00); tick();
    flag_op = 3'd0; expect_v("cli_edge2", K_IRQ, 8'h01); tick();
    flag_op = SEI; expect_v("sei_edge1", K_IRQ, 8'h01); tick();
    flag_op = 3'd0; expect_v("sei_edge2", K_IRQ, 8'h00); tick();
    flag_op = CLI; tick(); flag_op = 3'd0; tick();
    expect_v("irq_up", K_IRQ, 8'h01); drain();
    irq = 1'b0; expect_v("irq_drop", K_IRQ, 8'h00); tick();
    flag_op = SEI; tick(); flag_op = 3'd0;

    // NMI edge detection, ack, and set-wins.
    nmi = 1'b1; expect_v("nmi_rise", K_NMI, 8'h01); tick();
    expect_v("nmi_hold", K_NMI, 8'h01); tick();
    nmi_ack = 1'b1; expect_v("nmi_ack", K_NMI, 8'h00); tick();
    nmi_ack = 1'b0; expect_v("nmi_no_retrig", K_NMI, 8'h00); tick();
    nmi = 1'b0; tick();
    nmi = 1'b1; expect_v("nmi_rise2", K_NMI, 8'h01); tick();
    nmi = 1'b0; tick();
    nmi = 1'b1; nmi_ack = 1'b1; expect_v("nmi_set_wins", K_NMI, 8'h01); tick();
    nmi_ack = 1'b0; nmi = 1'b0;

    // Interrupt entry and decimal mode.
    flag_op = SED; expect_v("sed_before_int", K_P, 8'h2C); tick();
    flag_op = 3'd0; int_entry = 1'b1;
`ifdef STATUS_FLAGS_CMOS_DCLR_EN
    expect_v("int_entry_p", K_P, 8'h24); expect_v("int_entry_d", K_D2A, 8'h00);
`else
    expect_v("int_entry_p", K_P, 8'h2C); expect_v("int_entry_d", K_D2A, 8'h01);
`endif
    tick();
    flag_op = CLI; expect_v("int_over_cli", K_P, {5'b00100, p_out[2:0]} | 8'h04 | (p_out & 8'hC8)); tick();
    idle_inputs(); upd_bit = 1'b1; load_data = 8'hC0; alu_result = 8'h00;
`ifdef STATUS_FLAGS_CMOS_DCLR_EN
    expect_v("bit_p", K_P, 8'hE6);
`else
    expect_v("bit_p", K_P, 8'hEE);
`endif
    tick();

    // Random phase against the model.
    idle_inputs(); irq = 1'b0; nmi = 1'b0;
    rst = 1'b1; #1 rst = 1'b0;
    {m_n, m_v, m_d, m_i, m_z, m_c} = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    m_irq = 1'b0; m_nmi = 1'b0; m_prev = 1'b0;
    for (int k = 0; k < 300; k++) begin
      alu_result   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      alu_carry    = 1'($urandom); alu_overflow = 1'($urandom);
      upd_nz       = 1'($urandom); upd_c = 1'($urandom);
      upd_v        = 1'($urandom); upd_bit = ($urandom_range(0, 3) == 0);
      flag_op      = 3'($urandom);
      load_en      = ($urandom_range(0, 7) == 0);
      load_data    = 8'($urandom);
      int_entry    = ($urandom_range(0, 5) == 0);
      brk_push     = 1'($urandom);
      irq          = 1'($urandom);
      nmi          = ($urandom_range(0, 2) == 0) ? ~nmi : nmi;
      nmi_ack      = ($urandom_range(0, 3) == 0);
      model_step();
      expect_v("rnd_p", K_P, m_p());
      expect_v("rnd_push", K_PUSH, m_p() | {3'b000, brk_push, 4'b0000});
      expect_v("rnd_irq", K_IRQ, {7'd0, m_irq});
      expect_v("rnd_nmi", K_NMI, {7'd0, m_nmi});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
